// File: rtl/mod6_counter.sv
// Free-running modulo-MODULUS up-counter with terminal-count and one-hot phase decode.
// Optional wrap counter output enabled by defining MOD6_COUNTER_WRAP_CNT_EN.
module mod6_counter #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input  logic               clk,
  input  logic               reset,
  output logic [WIDTH-1:0]   q,
  output logic               tc,
  output logic [MODULUS-1:0] phase
`ifdef MOD6_COUNTER_WRAP_CNT_EN
  ,
  output logic [7:0]         wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Any value at or beyond the last legal state returns to 0, so upset states self-clear.
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (count_q >= LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    q     = count_q;
    tc    = (count_q == LAST);
    phase = '0;
    for (int i = 0; i < MODULUS; i++) begin
      phase[i] = (count_q == WIDTH'(i));
    end
  end

`ifdef MOD6_COUNTER_WRAP_CNT_EN
  logic [7:0] wrap_q;
  logic [7:0] wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (count_q == LAST) begin
      wrap_d = wrap_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_mod6_counter.sv
// Directed self-checking bench for mod6_counter (default MODULUS=6, WIDTH=3).
// Wrap counter checks are compiled in when MOD6_COUNTER_WRAP_CNT_EN is defined.
module tb_mod6_counter;

  logic       clk;
  logic       reset;
  logic [2:0] q;
  logic       tc;
  logic [5:0] phase;
`ifdef MOD6_COUNTER_WRAP_CNT_EN
  logic [7:0] wrap_cnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  mod6_counter #(.MODULUS(6), .WIDTH(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .q        (q),
    .tc       (tc),
    .phase    (phase)
`ifdef MOD6_COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives reset, lets the given number of rising edges pass, then settles 1 time unit past the edge.
  task automatic applyStimulus(input logic rst, input int edges);
    reset = rst;
    repeat (edges) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int expQ);
    logic [2:0] eq;
    logic       et;
    logic [5:0] ep;
    eq = 3'(expQ);
    et = (expQ == 5);
    ep = (expQ < 6) ? (6'b000001 << expQ) : 6'b000000;
    checkCount++;
    assert (q === eq) else begin
      errorCount++;
      $error("FAIL %s q: observed %0d expected %0d", tag, q, eq);
    end
    checkCount++;
    assert (tc === et) else begin
      errorCount++;
      $error("FAIL %s tc: observed %b expected %b", tag, tc, et);
    end
    checkCount++;
    assert (phase === ep) else begin
      errorCount++;
      $error("FAIL %s phase: observed %b expected %b", tag, phase, ep);
    end
  endtask

`ifdef MOD6_COUNTER_WRAP_CNT_EN
  task automatic checkWrap(input string tag, input logic [7:0] expW);
    checkCount++;
    assert (wrap_cnt === expW) else begin
      errorCount++;
      $error("FAIL %s wrap_cnt: observed %0d expected %0d", tag, wrap_cnt, expW);
    end
  endtask
`endif

  initial begin
    int seq [10] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};

    reset = 1'b1;
    applyStimulus(1'b1, 1);
    checkOutput("after_reset", 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1);
      checkOutput($sformatf("count_%0d", i), seq[i]);
    end

    applyStimulus(1'b0, 1);
    checkOutput("reach_five", 5);

    applyStimulus(1'b1, 1);
    checkOutput("reset_at_five", 0);
    applyStimulus(1'b0, 1);
    checkOutput("release_first", 1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1);
      checkOutput($sformatf("held_reset_%0d", i), 0);
    end

    applyStimulus(1'b0, 1);
    checkOutput("after_held", 1);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    applyStimulus(1'b0, 1);
    checkOutput("glitch_ignored", 2);
    applyStimulus(1'b0, 3);
    checkOutput("glitch_then_five", 5);
    applyStimulus(1'b0, 1);
    checkOutput("wrap_to_zero", 0);

`ifdef MOD6_COUNTER_WRAP_CNT_EN
    applyStimulus(1'b1, 1);
    checkWrap("wrap_reset", 8'd0);
    applyStimulus(1'b0, 13);
    checkOutput("wrap_13_edges", 1);
    checkWrap("wrap_two", 8'd2);
    applyStimulus(1'b1, 1);
    checkWrap("wrap_cleared", 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
